hilo_muldiv_seq: RTL and testbench
==================================

Name: hilo_muldiv_seq

Overview:
Multi-cycle sequencer for the CPU's HI/LO multiply/divide resource. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the control path and runs an iterative shift-add multiplier or restoring divider. It owns the HI/LO registers. While an operation is in flight it asserts a stall so that dependent HI/LO instructions wait. It sits beside the ALU in the execute stage and replaces single-cycle combinational mult/div.

Parameters:
BITS_PER_CYCLE, 1, quotient/product bits resolved per CALC cycle; legal values 1, 2, 4.
ITERS, 32/BITS_PER_CYCLE, derived; not overridable.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; low clears all state immediately
valid  input  1  request present on op/a/b this cycle
op  input  7  opcode: DIV=7, DIVU=8, MFHI=9, MFLO=10, MTHI=11, MTLO=12, MULT=13, MULTU=14; other codes ignored
a  input  32  rs operand (dividend / multiplicand / MTHI/MTLO source)
b  input  32  rt operand (divisor / multiplier)
flush  input  1  synchronous cancel of the in-flight operation
busy  output  1  operation in flight (CALC or FIXUP)
stall  output  1  combinational: busy & valid & op in {7..14}
done  output  1  one-cycle pulse: HI/LO updated by mult/div on the previous edge
div_by_zero  output  1  pulses together with done when a DIV/DIVU had b==0
hi  output  32  HI register
lo  output  32  LO register
r  output  32  combinational: hi for MFHI, lo for MFLO, 0 otherwise

Behaviour:
- Reset (reset low): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; internal accumulators cleared. Asynchronous. Aborts any operation without a partial HI/LO write.
- States: IDLE, CALC, FIXUP.
- IDLE, valid & !busy:
  - MTHI: hi<=a at that edge.
  - MTLO: lo<=a at that edge.
  - MFHI/MFLO: r is valid in the same cycle; no state change.
  - MULT/MULTU/DIV/DIVU: latch operands and op, then go to CALC with the iteration counter = 0.
    - Signed ops latch |a| and |b|, and record sign_q = a[31]^b[31] and sign_r = a[31].
    - Unsigned ops latch a and b unchanged.
- CALC: each edge resolves BITS_PER_CYCLE bits and increments the counter. After ITERS edges, go to FIXUP.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring divide on magnitudes; quotient and remainder are 32 bits.
- FIXUP (1 edge):
  - Apply signs: product negated if sign_q; quotient negated if sign_q; remainder negated if sign_r (result truncates toward zero).
  - Write hi/lo. Multiply: hi=product[63:32], lo=product[31:0]. Divide: lo=quotient, hi=remainder.
  - Go to IDLE. done=1 for the following cycle.
- Latency: accept edge E0, HI/LO written at edge E(ITERS+1). Default is E33; done is high during the cycle after E33.
- busy is high from after E0 until E(ITERS+1).
- Divide by zero: no iteration shortcut; full latency. Result lo=0xFFFFFFFF, hi=a (original, unsigned view). div_by_zero pulses with done.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This must fall out of the magnitude arithmetic with a 33-bit-safe negate; no overflow flag.
- valid while busy: request not accepted; stall=1 if op is in 7..14; hi/lo unchanged. The requester must hold valid/op/a/b until stall drops.
- Back-to-back: a request may be accepted in the done cycle, since busy is already 0 there.
- flush:
  - Sampled at each edge. In CALC or FIXUP it returns to IDLE with no HI/LO write and no done.
  - flush in IDLE blocks acceptance of that cycle's request.
  - flush takes priority over FIXUP completion at the same edge.
- Reset asserted mid-CALC: immediate IDLE with hi=lo=0; no done after release.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 33 cycles; after E33 hi=0xFFFFFFFE, lo=0x00000001; done one cycle.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero and done pulse together at 33 cycles; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 6*7 accepted, then MFLO held valid from E1 -> stall=1 through E33, stall=0 in the done cycle with r=42; MTHI 0x1234 while busy -> ignored; hi unchanged until the result is written.
- DIVU 100/7 with flush at E10 -> busy drops after E10, hi/lo keep prior values (e.g. after MTLO 0xAA: lo=0xAA), no done; then MTHI 0x55 in IDLE -> hi=0x55 next cycle.
- reset low at E15 of MULTU -> hi=lo=busy=0 immediately (before the next edge); after release MFHI -> r=0, no done.

Source files
------------

// File: rtl/hilo_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_seq_if
//  Description : Request/response bundle between the execute-stage control
//                path and the HI/LO multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hilo_muldiv_seq_if;
    logic        valid;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] r;

    modport master (
        output valid, op, a, b, flush,
        input  busy, stall, done, div_by_zero, hi, lo, r
    );

    modport slave (
        input  valid, op, a, b, flush,
        output busy, stall, done, div_by_zero, hi, lo, r
    );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_seq
//  Description : Iterative shift-add multiplier / restoring divider owning the
//                HI/LO registers. Stalls dependent HI/LO requests while busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_seq #(
    parameter int BITS_PER_CYCLE = 1    // legal: 1, 2, 4
) (
    input  wire                  clk,
    input  wire                  reset,  // asynchronous, active-low
    hilo_muldiv_seq_if.slave     bus
);

    localparam int         ITERS  = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] c_LAST = 6'(ITERS - 1);

    localparam logic [6:0] c_OP_DIV   = 7'd7;
    localparam logic [6:0] c_OP_DIVU  = 7'd8;
    localparam logic [6:0] c_OP_MFHI  = 7'd9;
    localparam logic [6:0] c_OP_MFLO  = 7'd10;
    localparam logic [6:0] c_OP_MTHI  = 7'd11;
    localparam logic [6:0] c_OP_MTLO  = 7'd12;
    localparam logic [6:0] c_OP_MULT  = 7'd13;
    localparam logic [6:0] c_OP_MULTU = 7'd14;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_CALC  = 2'd1;
    localparam logic [1:0] c_S_FIXUP = 2'd2;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_dbz;
    logic [31:0] r_a_orig;
    // Multiply: multiplicand magnitude. Divide: divisor magnitude.
    logic [31:0] r_opnd;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [63:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_dbz_pulse;

    logic        w_is_signed;
    logic        w_is_div;
    logic        w_is_md;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [63:0] w_acc_next;
    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_hi_res;
    logic [31:0] w_lo_res;

    // Request decode and operand magnitudes (|0x80000000| stays 0x80000000 unsigned)
    always_comb begin
        w_is_signed = (bus.op == c_OP_MULT) || (bus.op == c_OP_DIV);
        w_is_div    = (bus.op == c_OP_DIV)  || (bus.op == c_OP_DIVU);
        w_is_md     = w_is_div || (bus.op == c_OP_MULT) || (bus.op == c_OP_MULTU);
        w_abs_a     = (w_is_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        w_abs_b     = (w_is_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    end

    // One CALC step: BITS_PER_CYCLE shift-add or restoring-divide iterations
    always_comb begin
        w_acc_next = r_acc;
        w_sum      = '0;
        w_rem_sh   = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_is_div) begin
                w_rem_sh = {w_acc_next[63:32], w_acc_next[31]};
                if (w_rem_sh >= {1'b0, r_opnd}) begin
                    w_rem_sh   = w_rem_sh - {1'b0, r_opnd};
                    w_acc_next = {w_rem_sh[31:0], w_acc_next[30:0], 1'b1};
                end else begin
                    w_acc_next = {w_rem_sh[31:0], w_acc_next[30:0], 1'b0};
                end
            end else begin
                w_sum      = {1'b0, w_acc_next[63:32]}
                           + (w_acc_next[0] ? {1'b0, r_opnd} : 33'd0);
                w_acc_next = {w_sum, w_acc_next[31:1]};
            end
        end
    end

    // Sign fixup and final HI/LO selection; divide by zero bypasses the signs
    always_comb begin
        w_prod   = r_sign_q ? (~r_acc + 64'd1) : r_acc;
        w_quot   = r_sign_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem    = r_sign_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        w_hi_res = w_prod[63:32];
        w_lo_res = w_prod[31:0];
        if (r_is_div) begin
            w_hi_res = r_dbz ? r_a_orig : w_rem;
            w_lo_res = r_dbz ? 32'hFFFF_FFFF : w_quot;
        end
    end

    // Sequencer: accept in IDLE, iterate in CALC, commit in FIXUP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_S_IDLE;
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz       <= 1'b0;
            r_a_orig    <= '0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.valid && !bus.flush) begin
                        if (bus.op == c_OP_MTHI) begin
                            r_hi <= bus.a;
                        end else if (bus.op == c_OP_MTLO) begin
                            r_lo <= bus.a;
                        end else if (w_is_md) begin
                            r_state  <= c_S_CALC;
                            r_cnt    <= '0;
                            r_is_div <= w_is_div;
                            r_sign_q <= w_is_signed & (bus.a[31] ^ bus.b[31]);
                            r_sign_r <= w_is_signed & bus.a[31];
                            r_dbz    <= w_is_div & (bus.b == 32'd0);
                            r_a_orig <= bus.a;
                            r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                            r_acc    <= {32'd0, (w_is_div ? w_abs_a : w_abs_b)};
                        end
                    end
                end
                c_S_CALC: begin
                    if (bus.flush) begin
                        r_state <= c_S_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == c_LAST) begin
                            r_state <= c_S_FIXUP;
                        end
                    end
                end
                c_S_FIXUP: begin
                    r_state <= c_S_IDLE;
                    if (!bus.flush) begin
                        r_hi        <= w_hi_res;
                        r_lo        <= w_lo_res;
                        r_done      <= 1'b1;
                        r_dbz_pulse <= r_dbz;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    // Status outputs and same-cycle MFHI/MFLO read port
    always_comb begin
        bus.busy        = (r_state != c_S_IDLE);
        bus.stall       = bus.busy && bus.valid
                       && (bus.op >= c_OP_DIV) && (bus.op <= c_OP_MULTU);
        bus.done        = r_done;
        bus.div_by_zero = r_dbz_pulse;
        bus.hi          = r_hi;
        bus.lo          = r_lo;
        bus.r           = (bus.op == c_OP_MFHI) ? r_hi :
                          (bus.op == c_OP_MFLO) ? r_lo : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_seq
//  Description : Directed-vector bench with a scoreboard queue for HI/LO results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_seq;

    localparam logic [6:0] c_DIV   = 7'd7;
    localparam logic [6:0] c_DIVU  = 7'd8;
    localparam logic [6:0] c_MFHI  = 7'd9;
    localparam logic [6:0] c_MFLO  = 7'd10;
    localparam logic [6:0] c_MTHI  = 7'd11;
    localparam logic [6:0] c_MTLO  = 7'd12;
    localparam logic [6:0] c_MULT  = 7'd13;
    localparam logic [6:0] c_MULTU = 7'd14;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];

    hilo_muldiv_seq_if bus();

    hilo_muldiv_seq #(.BITS_PER_CYCLE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result_hi", bus.hi, e.hi);
                chk("result_lo", bus.lo, e.lo);
                chk("result_dbz", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
                chk("result_cycle", cyc, e.cyc);
            end
        end else if (reset && bus.div_by_zero) begin
            total++;
            bad++;
            $display("FAIL dbz_without_done: got 1 expected 0");
        end
    end

    task automatic issue(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int c0);
        @(negedge clk);
        bus.valid = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.valid = 1'b0;
        bus.op    = 7'd0;
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l, input logic z, input int c0);
        exp_t e;
        e.hi = h; e.lo = l; e.dbz = z; e.cyc = c0 + 33;
        sb_q.push_back(e);
    endtask

    // Counts negedges with busy high; returns in the cycle busy falls
    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input logic ez);
        int c0;
        int n;
        issue(o, x, y, c0);
        push(eh, el, ez, c0);
        wait_idle(n);
        chk("busy_cycles", n, 33);
    endtask

    initial begin
        int c0;
        int n;
        int st;
        logic hi_moved;

        bus.valid = 1'b0;
        bus.op    = 7'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        reset = 1'b1;

        // Arithmetic vectors
        run_op(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(negedge clk);
        bus.valid = 1'b1; bus.op = c_MFHI;
        #1 chk("mfhi_idle", bus.r, 32'hFFFF_FFFE);
        bus.valid = 1'b0; bus.op = 7'd0;
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        run_op(c_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op(c_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(c_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        1'b0);
        run_op(c_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 1'b1);
        run_op(c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0);

        // Stall: MTHI ignored while busy, MFLO held until the result lands
        issue(c_MULTU, 32'd6, 32'd7, c0);
        push(32'd0, 32'd42, 1'b0, c0);
        bus.valid = 1'b1; bus.op = c_MTHI; bus.a = 32'h1234;
        @(negedge clk);
        chk("stall_mthi", {31'd0, bus.stall}, 32'd1);
        @(posedge clk);
        #1;
        bus.op = c_MFLO; bus.a = 32'd0;
        n = 0; st = 0; hi_moved = 1'b0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            n++;
            if (bus.stall) st++;
            if (bus.hi !== 32'd0) hi_moved = 1'b1;
            @(negedge clk);
        end
        chk("stall_busy_cycles", n, 32);
        chk("stall_all_cycles", st, n);
        chk("hi_unchanged_busy", {31'd0, hi_moved}, 32'd0);
        chk("stall_done_cycle", {31'd0, bus.stall}, 32'd0);
        chk("r_mflo_done", bus.r, 32'd42);
        bus.valid = 1'b0; bus.op = 7'd0;

        // Flush mid-CALC: no write, no done
        issue(c_MTLO, 32'hAA, 32'd0, c0);
        issue(c_DIVU, 32'd100, 32'd7, c0);
        while (cyc < c0 + 9) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_lo", bus.lo, 32'hAA);
        chk("flush_hi", bus.hi, 32'd0);
        repeat (40) @(negedge clk);
        // flush in IDLE blocks acceptance
        bus.flush = 1'b1;
        issue(c_MTLO, 32'h77, 32'd0, c0);
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_idle_lo", bus.lo, 32'hAA);
        issue(c_MTHI, 32'h55, 32'd0, c0);
        @(negedge clk);
        chk("mthi_idle", bus.hi, 32'h55);

        // Asynchronous reset mid-CALC
        issue(c_MULTU, 32'd3, 32'd4, c0);
        while (cyc < c0 + 15) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_hi", bus.hi, 32'd0);
        chk("arst_lo", bus.lo, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.valid = 1'b1; bus.op = c_MFHI;
        @(negedge clk);
        chk("arst_mfhi", bus.r, 32'd0);
        bus.valid = 1'b0; bus.op = 7'd0;
        repeat (40) @(negedge clk);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
